// File: rtl/rvv_wb_rr_arb.sv
// Round-robin arbiter for the shared VRF write-back port.
// NREQ producers compete for one registered output slot (wb_*). The output
// register is refilled whenever it is empty or draining, so a stream of beats
// moves at one beat per cycle.
// Optional grant locking: define RVV_WB_ARB_LOCK_EN. A requester can then keep
// the port across several beats. Without the macro, req_lock is ignored.
//
// Lock FSM (RVV_WB_ARB_LOCK_EN only)
//   state  | meaning
//   IDLE   | plain round robin starting at ptr
//   LOCKED | only lock_id may be granted; ptr frozen until release

module rvv_wb_rr_arb #(
    parameter int NREQ = 4,
    parameter int AW   = 5,
    parameter int DW   = 128
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  logic [NREQ*AW-1:0]         req_addr,
    input  logic [NREQ*DW-1:0]         req_data,
    input  logic [NREQ-1:0]            req_lock,
    output logic                       wb_valid,
    input  logic                       wb_ready,
    output logic [AW-1:0]              wb_addr,
    output logic [DW-1:0]              wb_data,
    output logic [$clog2(NREQ)-1:0]    wb_src
);

    localparam int SW = $clog2(NREQ);

    logic [SW-1:0] ptr;
    logic [SW-1:0] grant_idx;
    logic          grant_any;
    logic          load;
    logic [SW:0]   cand_sum;
    logic [SW-1:0] cand;

`ifdef RVV_WB_ARB_LOCK_EN
    typedef enum logic {IDLE, LOCKED} state_t;
    state_t        state;
    logic [SW-1:0] lock_id;
`else
    logic          unused_lock;
    assign unused_lock = ^req_lock;
`endif

    function automatic logic [SW-1:0] next_ptr(input logic [SW-1:0] i);
        return (int'(i) == NREQ - 1) ? '0 : i + SW'(1);
    endfunction

    assign load = !wb_valid || wb_ready;

    // Pick the first valid requester at or after ptr, wrapping around.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand_sum  = '0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand_sum = {1'b0, ptr} + (SW+1)'(k);
            if (cand_sum >= (SW+1)'(NREQ)) begin
                cand_sum = cand_sum - (SW+1)'(NREQ);
            end
            cand = cand_sum[SW-1:0];
            if (!grant_any && req_valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
`ifdef RVV_WB_ARB_LOCK_EN
        if (state == LOCKED) begin
            grant_any = req_valid[lock_id];
            grant_idx = lock_id;
        end
`endif
    end

    // Ready only for the winner, only when the output slot can take a beat;
    // held low while reset is asserted so nothing is handshaken into a flop in reset.
    always_comb begin
        req_ready = '0;
        if (grant_any && load && rst_n) begin
            req_ready = NREQ'(1) << grant_idx;
        end
    end

    // Output register, round-robin pointer and lock FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid <= 1'b0;
            wb_addr  <= '0;
            wb_data  <= '0;
            wb_src   <= '0;
            ptr      <= '0;
`ifdef RVV_WB_ARB_LOCK_EN
            state    <= IDLE;
            lock_id  <= '0;
`endif
        end else if (load) begin
            wb_valid <= grant_any;
            if (grant_any) begin
                wb_addr <= req_addr[grant_idx*AW +: AW];
                wb_data <= req_data[grant_idx*DW +: DW];
                wb_src  <= grant_idx;
`ifdef RVV_WB_ARB_LOCK_EN
                case (state)
                    IDLE: begin
                        if (req_lock[grant_idx]) begin
                            state   <= LOCKED;
                            lock_id <= grant_idx;
                        end else begin
                            ptr <= next_ptr(grant_idx);
                        end
                    end
                    LOCKED: begin
                        if (!req_lock[grant_idx]) begin
                            state <= IDLE;
                            ptr   <= next_ptr(grant_idx);
                        end
                    end
                    default: state <= IDLE;
                endcase
`else
                ptr <= next_ptr(grant_idx);
`endif
            end
        end
    end

endmodule

// File: tb/tb_rvv_wb_rr_arb.sv
// Bench for rvv_wb_rr_arb: directed table, hand-written lock/reset sequences,
// and a randomized run against a queue-free behavioural model.

module tb_rvv_wb_rr_arb;

    localparam int NREQ = 4;
    localparam int AW   = 5;
    localparam int DW   = 128;
`ifdef RVV_WB_ARB_LOCK_EN
    localparam bit LOCK_ON = 1'b1;
`else
    localparam bit LOCK_ON = 1'b0;
`endif

    logic                 clk;
    logic                 rst_n;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*DW-1:0]   req_data;
    logic [NREQ-1:0]      req_lock;
    logic                 wb_valid;
    logic                 wb_ready;
    logic [AW-1:0]        wb_addr;
    logic [DW-1:0]        wb_data;
    logic [1:0]           wb_src;

    rvv_wb_rr_arb #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data), .req_lock(req_lock),
        .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_addr(wb_addr), .wb_data(wb_data), .wb_src(wb_src)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;

    // behavioural model state
    int            m_ptr;
    bit            m_wbv;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    int            m_src;
    bit            m_locked;
    int            m_lock_id;

    typedef struct {
        logic [3:0] valid;
        logic       wbr;
        logic [3:0] exp_ready;
        logic       exp_wbv;
        logic [1:0] exp_src;
    } vec_t;

    vec_t tbl[17];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0; m_wbv = 0; m_addr = '0; m_data = '0; m_src = 0;
        m_locked = 0; m_lock_id = 0;
    endtask

    // Winner under the arbitration rules: lock owner only, else first valid from ptr.
    function automatic int m_grant(input logic [3:0] v);
        if (m_locked) return v[m_lock_id] ? m_lock_id : -1;
        for (int k = 0; k < NREQ; k++) begin
            if (v[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
        end
        return -1;
    endfunction

    // Called at posedge+1; applies inputs, checks ready at the negedge,
    // advances the model across the next posedge and checks wb_* after it.
    task automatic step(input logic [3:0] v, input logic wbr, input logic [3:0] lk,
                        output logic [3:0] seen_ready);
        int g;
        logic [3:0] er;
        req_valid = v; wb_ready = wbr; req_lock = lk;
        #4;
        g  = m_grant(v);
        er = (g >= 0 && (!m_wbv || wbr)) ? 4'(1 << g) : 4'b0000;
        seen_ready = req_ready;
        check("req_ready", DW'(req_ready), DW'(er));
        @(posedge clk);
        if (!m_wbv || wbr) begin
            if (g >= 0) begin
                m_wbv  = 1;
                m_addr = req_addr[g*AW +: AW];
                m_data = req_data[g*DW +: DW];
                m_src  = g;
                if (m_locked) begin
                    if (!lk[g]) begin
                        m_locked = 0;
                        m_ptr = (g + 1) % NREQ;
                    end
                end else if (LOCK_ON && lk[g]) begin
                    m_locked = 1;
                    m_lock_id = g;
                end else begin
                    m_ptr = (g + 1) % NREQ;
                end
            end else begin
                m_wbv = 0;
            end
        end
        #1;
        check("wb_valid", DW'(wb_valid), DW'(m_wbv));
        check("wb_addr",  DW'(wb_addr),  DW'(m_addr));
        check("wb_data",  wb_data,       m_data);
        check("wb_src",   DW'(wb_src),   DW'(m_src));
    endtask

    logic [3:0] seen;
    logic [1:0] exp5[4];
    logic [3:0] lk5[4];

    initial begin
        // directed table: fairness, backpressure, wrap/skip, idle
        for (int k = 0; k < 8; k++)
            tbl[k] = '{4'b1111, 1'b1, 4'(1 << (k % 4)), 1'b1, 2'(k % 4)};
        for (int k = 8; k < 11; k++)
            tbl[k] = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd3};
        tbl[11] = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0};
        tbl[12] = '{4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2};
        tbl[13] = '{4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1};
        tbl[14] = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2};
        tbl[15] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2};
        tbl[16] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 2'd2};

        exp5 = LOCK_ON ? '{2'd2, 2'd2, 2'd2, 2'd0} : '{2'd2, 2'd0, 2'd2, 2'd0};
        lk5  = '{4'b0100, 4'b0100, 4'b0000, 4'b0000};

        req_addr = {5'h14, 5'h13, 5'h0A, 5'h11};
        req_data = {128'h3333_0000, 128'h2222_0000, 128'hBEEF, 128'h1111_0000};

        // reset with every requester valid
        rst_n = 1'b0; req_valid = 4'b1111; wb_ready = 1'b1; req_lock = '0;
        model_reset();
        #2;
        check("rst_wb_valid",  DW'(wb_valid),  DW'(0));
        check("rst_req_ready", DW'(req_ready), DW'(0));
        check("rst_wb_src",    DW'(wb_src),    DW'(0));
        check("rst_wb_data",   wb_data,        DW'(0));
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            step(tbl[i].valid, tbl[i].wbr, 4'b0000, seen);
            check($sformatf("tbl%0d_ready", i), DW'(seen),     DW'(tbl[i].exp_ready));
            check($sformatf("tbl%0d_wbv", i),   DW'(wb_valid), DW'(tbl[i].exp_wbv));
            check($sformatf("tbl%0d_src", i),   DW'(wb_src),   DW'(tbl[i].exp_src));
            if (i == 13) begin
                check("skip_addr", DW'(wb_addr), DW'(5'h0A));
                check("skip_data", wb_data,      128'hBEEF);
            end
        end

        // lock sequence: bring ptr to 2, then req2 (locking) vs req0
        step(4'b0010, 1'b1, 4'b0000, seen);
        for (int i = 0; i < 4; i++) begin
            step(4'b0101, 1'b1, lk5[i], seen);
            check($sformatf("lock_src%0d", i), DW'(wb_src), DW'(exp5[i]));
        end
        step(4'b0100, 1'b1, 4'b0100, seen);
        check("lock2_src", DW'(wb_src), DW'(2));
        step(4'b0001, 1'b1, 4'b0000, seen);
        check("lock_idle_ready", DW'(seen), LOCK_ON ? DW'(4'b0000) : DW'(4'b0001));
        check("lock_idle_wbv",   DW'(wb_valid), LOCK_ON ? DW'(0) : DW'(1));
        step(4'b0100, 1'b1, 4'b0000, seen);
        check("unlock_src", DW'(wb_src), DW'(2));

        // mid-operation reset while holding a req3 beat
        step(4'b1000, 1'b1, 4'b0000, seen);
        check("pre_rst_src", DW'(wb_src), DW'(3));
        rst_n = 1'b0;
        #1;
        check("async_wb_valid", DW'(wb_valid), DW'(0));
        check("async_wb_src",   DW'(wb_src),   DW'(0));
        check("async_ready",    DW'(req_ready), DW'(0));
        model_reset();
        #1;
        rst_n = 1'b1;
        step(4'b1111, 1'b1, 4'b0000, seen);
        check("post_rst_ready", DW'(seen),   DW'(4'b0001));
        check("post_rst_src",   DW'(wb_src), DW'(0));

        // randomized run
        for (int n = 0; n < 3000; n++) begin
            for (int r = 0; r < NREQ; r++) begin
                req_addr[r*AW +: AW] = AW'($urandom);
                req_data[r*DW +: DW] = {$urandom, $urandom, $urandom, $urandom};
            end
            step(4'($urandom), $urandom_range(0, 3) != 0,
                 4'($urandom) & 4'($urandom), seen);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
